// File: rtl/cipher_block_uart_tx.sv
// Serialises one accepted 64-bit block as 16 uppercase ASCII hex characters on a UART 8N1 line,
// most significant nibble first, optionally followed by CR LF.
module cipher_block_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter bit          SEND_CRLF    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] block_in,
    input  logic        block_valid,
    output logic        block_ready,
    output logic        tx,
    output logic        busy,
    output logic        done
);
    localparam int unsigned NCHARS = SEND_CRLF ? 18 : 16;
    localparam int unsigned CW     = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StDone} state_e;

    state_e        r_state, w_state_next;
    logic [CW-1:0] r_baud, w_baud_next;
    logic [2:0]    r_bit, w_bit_next;
    logic [4:0]    r_idx, w_idx_next;
    logic [7:0]    r_shift, w_shift_next;
    logic [63:0]   r_hold, w_hold_next;
    logic          r_tx, w_tx_next;
    logic          w_baud_wrap;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [7:0] char_at(input logic [63:0] hold, input logic [4:0] idx);
        logic [5:0] sh;
        sh = 6'd60 - {idx[3:0], 2'b00};
        if (idx == 5'd16) return 8'h0D;
        else if (idx == 5'd17) return 8'h0A;
        else return hex_char(hold[sh +: 4]);
    endfunction

    assign w_baud_wrap = (r_baud == CW'(CLKS_PER_BIT - 1));

    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud;
        w_bit_next   = r_bit;
        w_idx_next   = r_idx;
        w_shift_next = r_shift;
        w_hold_next  = r_hold;
        w_tx_next    = r_tx;
        unique case (r_state)
            StIdle: begin
                w_tx_next = 1'b1;
                if (block_valid) begin
                    w_hold_next  = block_in;
                    w_shift_next = hex_char(block_in[63:60]);
                    w_idx_next   = 5'd0;
                    w_baud_next  = '0;
                    w_bit_next   = 3'd0;
                    w_tx_next    = 1'b0;
                    w_state_next = StStart;
                end
            end
            StStart: begin
                w_baud_next = r_baud + CW'(1);
                if (w_baud_wrap) begin
                    w_baud_next  = '0;
                    w_bit_next   = 3'd0;
                    w_tx_next    = r_shift[0];
                    w_state_next = StData;
                end
            end
            StData: begin
                w_baud_next = r_baud + CW'(1);
                if (w_baud_wrap) begin
                    w_baud_next = '0;
                    w_bit_next  = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        w_tx_next    = 1'b1;
                        w_state_next = StStop;
                    end else begin
                        w_shift_next = {1'b0, r_shift[7:1]};
                        w_tx_next    = r_shift[1];
                    end
                end
            end
            StStop: begin
                w_baud_next = r_baud + CW'(1);
                if (w_baud_wrap) begin
                    w_baud_next = '0;
                    // Next character follows the stop bit with no idle gap.
                    if (r_idx < 5'(NCHARS - 1)) begin
                        w_idx_next   = r_idx + 5'd1;
                        w_shift_next = char_at(r_hold, r_idx + 5'd1);
                        w_tx_next    = 1'b0;
                        w_state_next = StStart;
                    end else begin
                        w_state_next = StDone;
                    end
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_tx_next    = 1'b1;
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_idx   <= 5'd0;
            r_shift <= 8'd0;
            r_hold  <= 64'd0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_baud  <= w_baud_next;
            r_bit   <= w_bit_next;
            r_idx   <= w_idx_next;
            r_shift <= w_shift_next;
            r_hold  <= w_hold_next;
            r_tx    <= w_tx_next;
        end
    end

    assign tx          = r_tx;
    assign block_ready = (r_state == StIdle);
    assign busy        = (r_state != StIdle);
    assign done        = (r_state == StDone);
endmodule

// File: tb/tb_cipher_block_uart_tx.sv
// Bench for cipher_block_uart_tx: two instances (with and without CR LF), UART decoders on both
// lines, and a string-level reference model for the expected character stream.
module tb_cipher_block_uart_tx;
    localparam int unsigned P = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] blk_v [2];
    logic [1:0]  valid_v, ready_v, tx_v, busy_v, done_v;

    int          n_checks = 0;
    int          n_errors = 0;
    int          done_cnt [2];
    logic [9:0]  rxq [2][$];
    logic [7:0]  exp_q [$];

    always #5 clk = ~clk;

    cipher_block_uart_tx #(.CLKS_PER_BIT(P), .SEND_CRLF(1'b1)) u_dut_crlf (
        .clk(clk), .rst(rst), .block_in(blk_v[0]), .block_valid(valid_v[0]),
        .block_ready(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0])
    );

    cipher_block_uart_tx #(.CLKS_PER_BIT(P), .SEND_CRLF(1'b0)) u_dut_hex (
        .clk(clk), .rst(rst), .block_in(blk_v[1]), .block_valid(valid_v[1]),
        .block_ready(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1])
    );

    // Line decoders: sample mid-bit on falling clock edges; a reset drops any partial frame.
    for (genvar g = 0; g < 2; g++) begin : g_mon
        int         cnt;
        logic       active;
        logic [9:0] fr;
        always @(negedge clk or posedge rst) begin
            if (rst) begin
                active <= 1'b0;
                cnt    <= 0;
            end else if (!active) begin
                if (tx_v[g] == 1'b0) begin
                    active <= 1'b1;
                    cnt    <= 1;
                end
            end else begin
                cnt <= cnt + 1;
                if (cnt % P == P / 2) begin
                    fr[cnt / P] <= tx_v[g];
                    if (cnt / P == 9) begin
                        rxq[g].push_back({tx_v[g], fr[8:0]});
                        active <= 1'b0;
                    end
                end
            end
        end
        always @(negedge clk) if (!rst && done_v[g]) done_cnt[g] <= done_cnt[g] + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void push_model(input logic [63:0] b, input bit crlf);
        for (int i = 0; i < 16; i++) begin
            int n;
            n = int'((b >> (60 - 4 * i)) & 64'hF);
            exp_q.push_back(n < 10 ? 8'(48 + n) : 8'(65 + n - 10));
        end
        if (crlf) begin
            exp_q.push_back(8'd13);
            exp_q.push_back(8'd10);
        end
    endfunction

    task automatic compare_rx(input int sel, input string tag);
        check({tag, " nchars"}, 64'(rxq[sel].size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rxq[sel].size(); i++)
            check($sformatf("%s frame%0d", tag, i), rxq[sel][i], {1'b1, exp_q[i], 1'b0});
        rxq[sel].delete();
        exp_q.delete();
    endtask

    task automatic wait_ready(input int sel, input string tag);
        int w;
        w = 0;
        while (!ready_v[sel] && w < 5000) begin
            @(negedge clk);
            w++;
        end
        check({tag, " ready"}, ready_v[sel], 1'b1);
    endtask

    task automatic send_and_check(input int sel, input logic [63:0] blk, input string tag);
        int cyc, dcnt, dat;
        wait_ready(sel, tag);
        blk_v[sel]   = blk;
        valid_v[sel] = 1'b1;
        @(negedge clk);
        valid_v[sel] = 1'b0;
        check({tag, " start bit"}, tx_v[sel], 1'b0);
        cyc = 0; dcnt = 0; dat = 0;
        while (busy_v[sel] && cyc < 5000) begin
            cyc++;
            if (done_v[sel]) begin
                dcnt++;
                dat = cyc;
            end
            @(negedge clk);
        end
        check({tag, " busy cycles"}, 64'(cyc), (sel == 0) ? 64'd721 : 64'd641);
        check({tag, " done pulses"}, 64'(dcnt), 64'd1);
        check({tag, " done position"}, 64'(dat), 64'(cyc));
        check({tag, " ready after"}, ready_v[sel], 1'b1);
        push_model(blk, sel == 0);
        compare_rx(sel, tag);
    endtask

    // Valid stays high through the first block while block_in changes to the second one.
    task automatic back_to_back(input logic [63:0] b1, input logic [63:0] b2, input string tag);
        int w;
        wait_ready(0, tag);
        blk_v[0]   = b1;
        valid_v[0] = 1'b1;
        @(negedge clk);
        check({tag, " busy1"}, busy_v[0], 1'b1);
        repeat (100) @(negedge clk);
        blk_v[0] = b2;
        w = 0;
        while (!done_v[0] && w < 2000) begin
            @(negedge clk);
            w++;
        end
        check({tag, " done1"}, done_v[0], 1'b1);
        check({tag, " gap tx done"}, tx_v[0], 1'b1);
        check({tag, " ready in done"}, ready_v[0], 1'b0);
        @(negedge clk);
        check({tag, " gap tx idle"}, tx_v[0], 1'b1);
        check({tag, " ready idle"}, ready_v[0], 1'b1);
        check({tag, " busy idle"}, busy_v[0], 1'b0);
        @(negedge clk);
        valid_v[0] = 1'b0;
        check({tag, " start2"}, tx_v[0], 1'b0);
        check({tag, " busy2"}, busy_v[0], 1'b1);
        w = 0;
        while (busy_v[0] && w < 2000) begin
            @(negedge clk);
            w++;
        end
        check({tag, " end2"}, busy_v[0], 1'b0);
        push_model(b1, 1'b1);
        push_model(b2, 1'b1);
        compare_rx(0, tag);
    endtask

    initial begin
        int bad, dsave;
        valid_v  = 2'b00;
        blk_v[0] = 64'd0;
        blk_v[1] = 64'd0;
        repeat (3) @(negedge clk);
        check("reset tx", tx_v, 2'b11);
        check("reset ready", ready_v, 2'b11);
        check("reset busy", busy_v, 2'b00);
        check("reset done", done_v, 2'b00);
        rst = 1'b0;

        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (tx_v != 2'b11 || ready_v != 2'b11 || done_v != 2'b00) bad++;
        end
        check("idle bad cycles", 64'(bad), 64'd0);
        check("idle done count", 64'(done_cnt[0] + done_cnt[1]), 64'd0);

        send_and_check(0, 64'hFEDCBA9876543210, "fedc");
        send_and_check(1, 64'h0000000000000000, "zeros nocrlf");
        back_to_back(64'hA5A5A5A5A5A5A5A5, 64'hFFFFFFFFFFFFFFFF, "a5 then ff");

        wait_ready(0, "reset mid");
        blk_v[0]   = {$urandom, $urandom};
        valid_v[0] = 1'b1;
        @(negedge clk);
        valid_v[0] = 1'b0;
        repeat (5 * 40 + 12) @(negedge clk);
        check("reset mid busy before", busy_v[0], 1'b1);
        dsave = done_cnt[0];
        #2 rst = 1'b1;
        #1;
        check("reset mid tx", tx_v[0], 1'b1);
        check("reset mid ready", ready_v[0], 1'b1);
        check("reset mid busy", busy_v[0], 1'b0);
        check("reset mid done", done_v[0], 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (50) @(negedge clk);
        check("reset mid no done", 64'(done_cnt[0]), 64'(dsave));
        rxq[0].delete();
        send_and_check(0, 64'h0123456789ABCDEF, "after reset");

        back_to_back(64'h1122334455667788, 64'hAABBCCDDEEFF0011, "b2b");

        for (int i = 0; i < 3; i++) send_and_check(0, {$urandom, $urandom}, $sformatf("rand crlf%0d", i));
        for (int i = 0; i < 2; i++) send_and_check(1, {$urandom, $urandom}, $sformatf("rand hex%0d", i));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/cipher_block_uart_tx.md
Name: cipher_block_uart_tx

Overview:
Output end of the 64-bit cipher datapath. It accepts one 64-bit block (ciphertext or decrypted message) on a valid/ready handshake. It transmits the block over a UART 8N1 line as 16 uppercase ASCII hex characters, most significant nibble first, optionally followed by CR LF. It sits between the DES-style core output and the board's USB-UART TX pin, mirroring the switch-driven key/message input side.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200 baud); must be >= 2
SEND_CRLF, 1, 1 = append 0x0D 0x0A after the 16 hex chars; 0 = hex chars only

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
block_in  input  64  block to transmit; sampled only on handshake
block_valid  input  1  block_in holds a block to send
block_ready  output  1  block can be accepted this cycle
tx  output  1  UART serial line, idle high
busy  output  1  high from acceptance until final stop bit completes
done  output  1  one-cycle pulse when a full block has been sent

Behaviour:
- Reset (async, immediate): tx=1, block_ready=1, busy=0, done=0, FSM=IDLE, all counters 0, shift/hold registers 0. A reset mid-frame aborts the frame; tx returns high immediately and the block is discarded.
- Handshake: a block is accepted on a rising edge where block_valid && block_ready. block_in is latched into a 64-bit hold register. block_ready is high only in IDLE and goes low the cycle after acceptance. block_in and block_valid are ignored while busy. If block_valid is held with no block_ready, nothing happens.
- Character count: NCHARS = 16 + 2*SEND_CRLF. Characters are indexed 0..NCHARS-1.
  - Chars 0..15 take nibble hold[63-4i -: 4].
  - Nibble 0-9 encodes to 0x30+n. Nibble A-F encodes to 0x41+(n-10).
  - Char 16 = 0x0D, char 17 = 0x0A.
- FSM states: IDLE -> START -> DATA -> STOP -> (START for next char | DONE) -> IDLE.
  - IDLE: tx=1. On accept, load char 0 into the 8-bit shift register and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. A 3-bit bit counter wraps 7 -> STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. If char index < NCHARS-1, increment the index, load the next char, and go to START with no idle gap. Otherwise go to DONE.
  - DONE: lasts one cycle. done=1 and busy=0, block_ready=1 in the following IDLE cycle.
- Latency:
  - tx falls on the first clk edge after acceptance; the start bit begins the cycle after the handshake.
  - Total busy time = NCHARS*10*CLKS_PER_BIT + 1 cycles (the +1 is DONE).
  - A new block can be accepted the cycle after done.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary. It is reset to 0 on every state entry.
- Outputs are registered; tx has no combinational path from inputs.
- busy = (state != IDLE). done is low in every state except DONE.

Test Plan:
- CLKS_PER_BIT=4, SEND_CRLF=1, send 64'hFEDCBA9876543210 -> UART monitor decodes "FEDCBA9876543210\r\n". First frame on tx is 0,0,1,1,0,0,0,1,0,1 (start, 0x46 LSB-first, stop). done pulses exactly 721 cycles after acceptance.
- Send 64'h0000000000000000 with SEND_CRLF=0 -> sixteen 0x30 chars. busy lasts 641 cycles. No 0x0D/0x0A is emitted.
- Send 64'hA5A5A5A5A5A5A5A5, then change block_in to 64'hFFFFFFFFFFFFFFFF and keep block_valid high mid-transmission -> output stays "A5A5A5A5A5A5A5A5\r\n". The second block is accepted only the cycle after done and then sent as "FFFFFFFFFFFFFFFF\r\n".
- Assert rst asynchronously (between clk edges) during the DATA bit of char 5 -> tx=1, block_ready=1, busy=0 immediately. No done pulse. A subsequent block 64'h0123456789ABCDEF sends cleanly as "0123456789ABCDEF\r\n".
- Hold block_valid=0 for 1000 cycles after reset -> tx constantly 1, block_ready constantly 1, done never asserted.
- Back-to-back: drive block_valid continuously with 64'h1122334455667788 then 64'hAABBCCDDEEFF0011 -> both strings are received in order. The gap between the last stop bit of block 1 and the start bit of block 2 is exactly 2 cycles (DONE plus the IDLE accept cycle).
